// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer and its MAC.
package conv_pkg;

  localparam int PIX_W  = 3;
  localparam int COEF_W = 5;
  localparam int ACC_W  = 12;
  localparam int TAPS   = 9;
  localparam int TAP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE
  } state_t;

  // Neighbourhood offsets in tap order: row-major, top-left first.
  localparam int TAP_DX [TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int TAP_DY [TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  // Control tag that travels with each tap while its ROM data is in flight.
  typedef struct packed {
    logic vld;
    logic inr;
    logic first;
  } tap_tag_t;

  localparam int TAG_W = $bits(tap_tag_t);

  function automatic logic [7:0] clamp_coord(input int c, input int lim);
    if (c < 0)        return 8'd0;
    if (c > lim - 1)  return 8'(lim - 1);
    return 8'(c);
  endfunction

endpackage

// File: rtl/conv_if.sv
// Bus between the convolution sequencer and its ROMs, result RAM and host.
interface conv_if;
  import conv_pkg::*;

  logic                     start;
  logic [PIX_W-1:0]         pix_din;
  logic signed [COEF_W-1:0] ker_din;
  logic [7:0]               nine_x_addr;
  logic [7:0]               nine_y_addr;
  logic [TAP_W-1:0]         ker_addr;
  logic                     we;
  logic [7:0]               pix_x_addr;
  logic [7:0]               pix_y_addr;
  logic [PIX_W-1:0]         newpix;
  logic                     busy;
  logic                     done;
  logic                     en_vga;

  modport master (
    input  start, pix_din, ker_din,
    output nine_x_addr, nine_y_addr, ker_addr,
    output we, pix_x_addr, pix_y_addr, newpix,
    output busy, done, en_vga
  );

  modport slave (
    output start, pix_din, ker_din,
    input  nine_x_addr, nine_y_addr, ker_addr,
    input  we, pix_x_addr, pix_y_addr, newpix,
    input  busy, done, en_vga
  );

endinterface

// File: rtl/conv_mac.sv
// Tap multiply-accumulate with zero-padding, then shift and clamp to a pixel.
// Define CONV_ABS_EN to take the accumulator magnitude before shift/clamp.
module conv_mac
  import conv_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic                     clk_proc,
  input  logic                     rst,
  input  tap_tag_t                 tag,
  input  logic [PIX_W-1:0]         pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic [PIX_W-1:0]         result
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] pix_s;
  logic signed [ACC_W-1:0] coef_s;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] mag;
  logic signed [ACC_W-1:0] shifted;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    pix_s  = {{(ACC_W-PIX_W){1'b0}}, pix};
    coef_s = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
    prod   = tag.inr ? pix_s * coef_s : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_proc) begin
    if (rst) begin
      acc_q <= '0;
    end else if (tag.vld) begin
      acc_q <= (tag.first ? '0 : acc_q) + prod;
    end
  end

  always_comb begin
`ifdef CONV_ABS_EN
    mag = acc_q[ACC_W-1] ? -acc_q : acc_q;
`else
    mag = acc_q;
`endif
    shifted = mag >>> SHIFT;
    if (shifted[ACC_W-1])
      result = '0;
    else if (|shifted[ACC_W-2:PIX_W])
      result = '1;
    else
      result = shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/conv_sequencer.sv
// Frame controller: raster walk, 9-tap address issue, read-latency tracking
// and one result write per pixel on a fixed (10+RD_LAT)-cycle schedule.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int RD_LAT = 2,
  parameter int SHIFT  = 3
) (
  input  logic   clk_proc,
  input  logic   rst,
  conv_if.master bus
);

  localparam int DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t           state_q, state_n;
  logic [TAP_W-1:0] tap_q, tap_n;
  logic [7:0]       x_q, y_q, x_n, y_n;
  logic [DRN_W-1:0] drn_q, drn_n;
  logic             issue;
  logic             last_px;
  int               nx, ny;
  tap_tag_t         tag_n;
  tap_tag_t         tag_mac;
  logic [TAG_W*RD_LAT-1:0] pipe_q;
  logic [PIX_W-1:0] mac_result;

  assign last_px = (x_q == 8'(WIDTH-1)) && (y_q == 8'(HEIGHT-1));

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_n = ST_ISSUE;
      ST_ISSUE: if (tap_q == TAP_W'(TAPS-1)) state_n = ST_DRAIN;
      ST_DRAIN: if (drn_q == DRN_W'(RD_LAT-1)) state_n = ST_WRITE;
      ST_WRITE: state_n = last_px ? ST_IDLE : ST_ISSUE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Counter and tap-issue logic.
  always_comb begin
    tap_n = tap_q;
    x_n   = x_q;
    y_n   = y_q;
    drn_n = drn_q;
    issue = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          issue = 1'b1;
          tap_n = '0;
          x_n   = '0;
          y_n   = '0;
        end
      end
      ST_ISSUE: begin
        if (tap_q == TAP_W'(TAPS-1)) begin
          drn_n = '0;
        end else begin
          issue = 1'b1;
          tap_n = tap_q + TAP_W'(1);
        end
      end
      ST_DRAIN: drn_n = drn_q + DRN_W'(1);
      ST_WRITE: begin
        if (!last_px) begin
          issue = 1'b1;
          tap_n = '0;
          if (x_q == 8'(WIDTH-1)) begin
            x_n = '0;
            y_n = y_q + 8'd1;
          end else begin
            x_n = x_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    nx          = int'(x_n) + TAP_DX[tap_n];
    ny          = int'(y_n) + TAP_DY[tap_n];
    tag_n.vld   = issue;
    tag_n.inr   = (nx >= 0) && (nx < WIDTH) && (ny >= 0) && (ny < HEIGHT);
    tag_n.first = issue && (tap_n == '0);
  end

  always_ff @(posedge clk_proc) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      tap_q           <= '0;
      x_q             <= '0;
      y_q             <= '0;
      drn_q           <= '0;
      bus.nine_x_addr <= '0;
      bus.nine_y_addr <= '0;
      bus.ker_addr    <= '0;
      bus.we          <= 1'b0;
      bus.pix_x_addr  <= '0;
      bus.pix_y_addr  <= '0;
      bus.newpix      <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.en_vga      <= 1'b1;
    end else begin
      state_q <= state_n;
      tap_q   <= tap_n;
      x_q     <= x_n;
      y_q     <= y_n;
      drn_q   <= drn_n;
      if (issue) begin
        bus.nine_x_addr <= clamp_coord(nx, WIDTH);
        bus.nine_y_addr <= clamp_coord(ny, HEIGHT);
        bus.ker_addr    <= tap_n;
      end
      bus.we <= (state_n == ST_WRITE);
      if (state_n == ST_WRITE) begin
        bus.pix_x_addr <= x_q;
        bus.pix_y_addr <= y_q;
        bus.newpix     <= mac_result;
      end
      bus.busy   <= (state_n != ST_IDLE);
      bus.en_vga <= (state_n == ST_IDLE);
      bus.done   <= (state_q == ST_WRITE) && last_px;
    end
  end

  // NOTE: this tag pipeline is reset (unlike a data memory) so a stale valid bit cannot disturb the accumulator.
  always_ff @(posedge clk_proc) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= (pipe_q << TAG_W) | (TAG_W*RD_LAT)'(tag_n);
  end

  assign tag_mac = tap_tag_t'(pipe_q[TAG_W*RD_LAT-1 -: TAG_W]);

  conv_mac #(.SHIFT(SHIFT)) u_mac (
    .clk_proc (clk_proc),
    .rst      (rst),
    .tag      (tag_mac),
    .pix      (bus.pix_din),
    .coef     (bus.ker_din),
    .result   (mac_result)
  );

endmodule
